// File: rtl/count_seq_pkg.sv
// Shared types for the count job sequencer: FSM state encoding and the latched job record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// The job_t field widths follow CS_WIDTH/CS_IDW, so a sequencer built with non-default
// WIDTH/NUM_REQ must have these constants changed to match.
package count_seq_pkg;

    localparam int CS_WIDTH   = 4;
    localparam int CS_NUM_REQ = 4;
    localparam int CS_IDW     = $clog2(CS_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [CS_WIDTH-1:0] start;
        logic [CS_WIDTH-1:0] target;
        logic                dir;
        logic [CS_IDW-1:0]   id;
    } job_t;

endpackage

// File: rtl/count_job_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer, with wrap.
// Latency: grant is combinational; pointer advances on the clock edge where accept_i is high.
// Backpressure: grant_o is forced to zero while en_i is low; the pointer only moves on accept_i.
// Ports: clk, reset_n (async, active-low); req_i request vector; en_i grant enable;
//        accept_i handshake taken; grant_o one-hot grant; grant_idx_o winner index; any_o some request.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     grant_idx_o,
    output logic               any_o
);

    logic [IDW-1:0] ptr_q, ptr_d;

    // Scan offsets from the farthest to the nearest so the last hit, i.e. the
    // smallest distance from the pointer, is the one that sticks.
    always_comb begin
        int             cand;
        logic [IDW-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand     = (int'(ptr_q) + k) % NUM_REQ;
            cand_idx = IDW'(cand);
            if (req_i[cand_idx]) begin
                any_o       = 1'b1;
                grant_idx_o = cand_idx;
            end
        end
    end

    always_comb begin
        grant_o = '0;
        if (en_i && any_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            if (grant_idx_o == IDW'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/updown_counter_4bit.sv
// External 4-bit up/down counter with synchronous load; the sequencer drives its pins.
// Latency: count updates on the clock edge after load/up_down are presented.
// Backpressure: none; counts every cycle it is not loading.
// Ports: clk, reset_n (async, active-low, count restarts at 0); load, up_down, load_data in; count out.
module updown_counter_4bit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       up_down,
    input  logic [3:0] load_data,
    output logic [3:0] count
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_data;
        end else if (up_down) begin
            count_d = count_q + 4'd1;
        end else begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/count_job_sequencer.sv
// Shares one loadable up/down counter among NUM_REQ requesters; runs one count job at a time.
// Latency: handshake cycle 0, counter loaded in cycle 1, done_valid in cycle steps+3, next grant in steps+4.
// Backpressure: req_ready is offered only in IDLE, one-hot to the round-robin winner; zero otherwise.
// Ports: clk, reset_n (async, active-low); req_valid/req_ready/req_start/req_target/req_dir job inputs;
//        cnt_load/cnt_up_down/cnt_load_data drive the counter, cnt_count observes it;
//        busy, done_valid, done_id status. With COUNT_SEQ_ABORT_EN defined: abort in, done_aborted out.
module count_job_sequencer
    import count_seq_pkg::*;
#(
    parameter  int WIDTH   = CS_WIDTH,
    parameter  int NUM_REQ = CS_NUM_REQ,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_start,
    input  logic [NUM_REQ*WIDTH-1:0] req_target,
    input  logic [NUM_REQ-1:0]       req_dir,
    output logic                     cnt_load,
    output logic                     cnt_up_down,
    output logic [WIDTH-1:0]         cnt_load_data,
    input  logic [WIDTH-1:0]         cnt_count,
    output logic                     busy,
    output logic                     done_valid,
    output logic [IDW-1:0]           done_id
`ifdef COUNT_SEQ_ABORT_EN
    ,
    input  logic                     abort,
    output logic                     done_aborted
`endif
);

    seq_state_e     state_q, state_d;
    job_t           job_q, job_d;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic           accept;
    logic           abort_req;

    logic [WIDTH-1:0] start_arr  [NUM_REQ];
    logic [WIDTH-1:0] target_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign start_arr[i]  = req_start[i*WIDTH +: WIDTH];
        assign target_arr[i] = req_target[i*WIDTH +: WIDTH];
    end

    // A grant only ever goes to a valid requester, so grant-while-idle is the handshake.
    assign accept = (state_q == IDLE) && grant_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (req_valid),
        .en_i        (state_q == IDLE),
        .accept_i    (accept),
        .grant_o     (req_ready),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

`ifdef COUNT_SEQ_ABORT_EN
    logic aborted_q;

    assign abort_req = abort;

    // Remembers that the job entered DONE through an abort; cleared once back in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aborted_q <= 1'b0;
        end else if (state_q == IDLE) begin
            aborted_q <= 1'b0;
        end else if ((state_q == LOAD || state_q == RUN) && abort) begin
            aborted_q <= 1'b1;
        end
    end

    assign done_aborted = (state_q == DONE) && aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    // Default drive reloads the counter with its own value, which freezes it.
    always_comb begin
        state_d       = state_q;
        job_d         = job_q;
        cnt_load      = 1'b1;
        cnt_load_data = cnt_count;
        cnt_up_down   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    job_d.start  = start_arr[grant_idx];
                    job_d.target = target_arr[grant_idx];
                    job_d.dir    = req_dir[grant_idx];
                    job_d.id     = grant_idx;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                if (abort_req) begin
                    state_d = DONE;
                end else begin
                    cnt_load_data = job_q.start;
                    state_d       = RUN;
                end
            end
            RUN: begin
                if (abort_req || cnt_count == job_q.target) begin
                    state_d = DONE;
                end else begin
                    cnt_load    = 1'b0;
                    cnt_up_down = job_q.dir;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            job_q   <= '0;
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done_valid = (state_q == DONE);
    assign done_id    = (state_q == DONE) ? job_q.id : '0;

endmodule

// File: tb/tb_count_job_sequencer.sv
// Bench for count_job_sequencer driving a real updown_counter_4bit; scoreboard of expected jobs.
// Latency: n/a.
// Backpressure: requesters hold valid and fields until their ready is seen.
module tb_count_job_sequencer;

    localparam int W   = 4;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_start = '0;
    logic [N*W-1:0] req_target = '0;
    logic [N-1:0]   req_dir = '0;
    logic           cnt_load, cnt_up_down;
    logic [W-1:0]   cnt_load_data, cnt_count;
    logic           busy, done_valid;
    logic [IDW-1:0] done_id;
`ifdef COUNT_SEQ_ABORT_EN
    logic           abort = 1'b0;
    logic           done_aborted;
`endif

    always #5 clk = ~clk;

    count_job_sequencer #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_start     (req_start),
        .req_target    (req_target),
        .req_dir       (req_dir),
        .cnt_load      (cnt_load),
        .cnt_up_down   (cnt_up_down),
        .cnt_load_data (cnt_load_data),
        .cnt_count     (cnt_count),
        .busy          (busy),
        .done_valid    (done_valid),
        .done_id       (done_id)
`ifdef COUNT_SEQ_ABORT_EN
        ,
        .abort         (abort),
        .done_aborted  (done_aborted)
`endif
    );

    updown_counter_4bit u_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (cnt_load),
        .up_down   (cnt_up_down),
        .load_data (cnt_load_data),
        .count     (cnt_count)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int start;
        int target;
        int dir;
        int hs;
        int done_cyc;
        int final_v;
        bit aborted;
    } exp_t;

    exp_t q[$];
    int   grant_log[$];
    int   ptr_m = 0;
    int   hold_val = 0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected counter value in cycle c of job r: unchanged through the load cycle,
    // then start stepping by one per cycle in the job's direction.
    function automatic int traj(exp_t r, int c);
        int k;
        if (c <= r.hs + 1) return hold_val;
        k = c - r.hs - 2;
        if (r.dir != 0) return (r.start + k) & 15;
        return (r.start - k) & 15;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int           g;
        int           idx;
        int           d;
        exp_t         e;
        exp_rdy = '0;
        g       = -1;
        idx     = 0;
        d       = 0;
        if (!reset_n) begin
            check("rst_busy", int'(busy), 0);
            check("rst_done_valid", int'(done_valid), 0);
            check("rst_done_id", int'(done_id), 0);
            check("rst_count", int'(cnt_count), 0);
`ifdef COUNT_SEQ_ABORT_EN
            check("rst_done_aborted", int'(done_aborted), 0);
`endif
            q.delete();
            ptr_m    = 0;
            hold_val = 0;
        end else begin
            if (q.size() == 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (ptr_m + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", int'(req_ready), int'(exp_rdy));
            check("busy", int'(busy), int'(q.size() != 0));

            if (q.size() == 0) begin
                check("count_hold", int'(cnt_count), hold_val);
            end else if (cyc < q[0].done_cyc) begin
                check("count_traj", int'(cnt_count), traj(q[0], cyc));
            end

            if (done_valid) begin
                if (q.size() == 0) begin
                    check("done_valid_unexpected", int'(done_valid), 0);
                end else begin
                    check("done_cycle", cyc, q[0].done_cyc);
                    check("done_id", int'(done_id), q[0].id);
                    check("done_count", int'(cnt_count), q[0].final_v);
`ifdef COUNT_SEQ_ABORT_EN
                    check("done_aborted", int'(done_aborted), int'(q[0].aborted));
`endif
                    hold_val = q[0].final_v;
                    void'(q.pop_front());
                end
            end else if (q.size() != 0 && cyc >= q[0].done_cyc) begin
                check("done_valid_missing", int'(done_valid), 1);
                hold_val = q[0].final_v;
                void'(q.pop_front());
            end

`ifdef COUNT_SEQ_ABORT_EN
            if (abort && q.size() != 0 && cyc >= q[0].hs + 1 && cyc < q[0].done_cyc) begin
                q[0].final_v  = traj(q[0], cyc);
                q[0].done_cyc = cyc + 1;
                q[0].aborted  = 1'b1;
            end
`endif

            if (g >= 0 && req_ready[g]) begin
                e.id     = g;
                e.start  = int'(req_start[g*W +: W]);
                e.target = int'(req_target[g*W +: W]);
                e.dir    = int'(req_dir[g]);
                d = (e.dir != 0) ? ((e.target - e.start) & 15) : ((e.start - e.target) & 15);
                e.hs       = cyc;
                e.done_cyc = cyc + d + 3;
                e.final_v  = e.target;
                e.aborted  = 1'b0;
                q.push_back(e);
                grant_log.push_back(g);
                ptr_m = (g + 1) % N;
            end
        end
    end

    task automatic set_req(int i, int s, int t, int dir);
        req_valid[i]          = 1'b1;
        req_start[i*W +: W]   = W'(s);
        req_target[i*W +: W]  = W'(t);
        req_dir[i]            = dir[0];
    endtask

    task automatic wait_grant(int i);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (reset_n && req_valid[i] && req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        check("grant_wait", int'(ok), 1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (q.size() == 0) break;
        end
        check("idle_wait", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int     exp_g [5];
        logic [N-1:0] hs;
        exp_g = '{0, 1, 2, 3, 0};

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Up count 3 -> 5 from requester 0.
        set_req(0, 3, 5, 1);
        wait_grant(0);
        wait_idle();
        @(negedge clk);
        check("t1_final_count", int'(cnt_count), 5);

        // Down count with wrap 1 -> 14 from requester 2.
        set_req(2, 1, 14, 0);
        wait_grant(2);
        wait_idle();

        // Zero-step job from requester 1.
        set_req(1, 7, 7, 1);
        wait_grant(1);
        wait_idle();
        @(negedge clk);
        check("t3_final_count", int'(cnt_count), 7);

        // Reset while running; pending requesters 1 and 3 are then served from pointer 0.
        @(posedge clk);
        #1;
        set_req(2, 0, 10, 1);
        wait_grant(2);
        repeat (4) @(posedge clk);
        #1;
        set_req(3, 4, 2, 0);
        set_req(1, 2, 4, 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        grant_log.delete();
        wait_grant(1);
        wait_grant(3);
        wait_idle();
        check("rr_after_reset_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("rr_after_reset_first", grant_log[0], 1);
            check("rr_after_reset_second", grant_log[1], 3);
        end

        // All four held valid: fair rotation starting at 0.
        do_reset();
        grant_log.delete();
        for (int i = 0; i < N; i++) set_req(i, i, i + 1, 1);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (grant_log.size() >= 5) break;
        end
        #1;
        req_valid = '0;
        wait_idle();
        check("rr_all_count", grant_log.size(), 5);
        if (grant_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("rr_all_order", grant_log[i], exp_g[i]);
        end

`ifdef COUNT_SEQ_ABORT_EN
        // Abort in RUN at count 9 on the way to 12.
        set_req(0, 5, 12, 1);
        wait_grant(0);
        for (int k = 0; k < 30; k++) begin
            if (cnt_count == 4'd9) break;
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_idle();
        @(negedge clk);
        check("abort_hold_count", int'(cnt_count), 9);
        @(posedge clk);
        #1;
`endif

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            hs = req_valid & req_ready & {N{reset_n}};
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    req_start[i*W +: W]  = W'($urandom_range(15, 0));
                    req_target[i*W +: W] = W'($urandom_range(15, 0));
                    req_dir[i]           = 1'($urandom_range(1, 0));
                    if ($urandom_range(3, 0) == 0) req_valid[i] = 1'b1;
                end
            end
`ifdef COUNT_SEQ_ABORT_EN
            abort = ($urandom_range(15, 0) == 0);
`endif
        end
        req_valid = '0;
`ifdef COUNT_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
